// File: rtl/xprop_sweep_sequencer_if.sv
// Control and result bundle between the sweep sequencer and its harness.
// master = sequencer side, slave = harness / stimulus side.
interface xprop_sweep_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int NGROUPS = 9,
  parameter int CNTW    = 16
);
  logic                 start;
  logic                 abort;
  logic [NGROUPS-1:0]   grp_ok;
  logic [2*WIDTH-1:0]   in1_code;
  logic [2*WIDTH-1:0]   in2_code;
  logic                 vec_valid;
  logic                 sample;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNTW-1:0]      fail_count;
  logic [NGROUPS-1:0]   fail_mask;
  logic [4*WIDTH-1:0]   first_fail_idx;
  logic [NGROUPS-1:0]   first_fail_mask;
  logic                 first_fail_valid;

  modport master (
    input  start, abort, grp_ok,
    output in1_code, in2_code, vec_valid, sample,
    output busy, done, pass, fail_count, fail_mask,
    output first_fail_idx, first_fail_mask,
    output first_fail_valid
  );

  modport slave (
    output start, abort, grp_ok,
    input  in1_code, in2_code, vec_valid, sample,
    input  busy, done, pass, fail_count, fail_mask,
    input  first_fail_idx, first_fail_mask,
    input  first_fail_valid
  );
endinterface

// File: rtl/xprop_sweep_sequencer.sv
// Sweeps every 4-state code pair into a spec/impl DUT pair and scores grp_ok.
// Ports: clk, rst (sync, active high), bus = control/result bundle (master).
module xprop_sweep_sequencer #(
  parameter int WIDTH   = 4,
  parameter int NGROUPS = 9,
  parameter int SETTLE  = 4,
  parameter int CNTW    = 16
) (
  input  logic clk,
  input  logic rst,
  xprop_sweep_sequencer_if.master bus
);
  localparam int IW = 4 * WIDTH;
  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               sample_q, sample_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNTW-1:0]    fcnt_q, fcnt_d;
  logic [NGROUPS-1:0] fmask_q, fmask_d;
  logic [IW-1:0]      ff_idx_q, ff_idx_d;
  logic [NGROUPS-1:0] ff_mask_q, ff_mask_d;
  logic               ff_vld_q, ff_vld_d;
  logic               miss;

  assign miss = ~&bus.grp_ok;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fcnt_d    = fcnt_q;
    fmask_d   = fmask_q;
    ff_idx_d  = ff_idx_q;
    ff_mask_d = ff_mask_q;
    ff_vld_d  = ff_vld_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d   = S_SETTLE;
            idx_d     = '0;
            cnt_d     = RELOAD;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            fcnt_d    = '0;
            fmask_d   = '0;
            ff_idx_d  = '0;
            ff_mask_d = '0;
            ff_vld_d  = 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 8'd0) state_d = S_CHECK;
          else cnt_d = cnt_q - 8'd1;
        end
        S_CHECK: begin
          if (miss) begin
            if (!(&fcnt_q)) fcnt_d = fcnt_q + 1'b1;
            fmask_d = fmask_q | ~bus.grp_ok;
            if (!ff_vld_q) begin
              ff_idx_d  = idx_q;
              ff_mask_d = ~bus.grp_ok;
              ff_vld_d  = 1'b1;
            end
          end
          // N-1 is all ones, so idx never needs to wrap
          if (&idx_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (fcnt_d == '0);
          end else begin
            state_d = S_SETTLE;
            idx_d   = idx_q + 1'b1;
            cnt_d   = RELOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // sample/busy are registered copies of the next state's decode
  always_comb begin
    sample_d = (state_d == S_CHECK);
    busy_d   = (state_d == S_SETTLE) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fcnt_q    <= '0;
      fmask_q   <= '0;
      ff_idx_q  <= '0;
      ff_mask_q <= '0;
      ff_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fcnt_q    <= fcnt_d;
      fmask_q   <= fmask_d;
      ff_idx_q  <= ff_idx_d;
      ff_mask_q <= ff_mask_d;
      ff_vld_q  <= ff_vld_d;
    end
  end

  assign bus.in1_code         = idx_q[IW-1:2*WIDTH];
  assign bus.in2_code         = idx_q[2*WIDTH-1:0];
  assign bus.vec_valid        = busy_q;
  assign bus.sample           = sample_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fcnt_q;
  assign bus.fail_mask        = fmask_q;
  assign bus.first_fail_idx   = ff_idx_q;
  assign bus.first_fail_mask  = ff_mask_q;
  assign bus.first_fail_valid = ff_vld_q;
endmodule

// File: tb/tb_xprop_sweep_sequencer.sv
// Scoreboard bench for xprop_sweep_sequencer (WIDTH=1, NGROUPS=2, SETTLE=2).
// Second instance with CNTW=3 exercises fail counter saturation.
module tb_xprop_sweep_sequencer;
  localparam int WIDTH = 1;
  localparam int NG    = 2;
  localparam int SET   = 2;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xprop_sweep_sequencer_if #(.WIDTH(WIDTH), .NGROUPS(NG), .CNTW(16)) bus ();
  xprop_sweep_sequencer_if #(.WIDTH(WIDTH), .NGROUPS(NG), .CNTW(3))  sbus ();

  xprop_sweep_sequencer #(
    .WIDTH(WIDTH), .NGROUPS(NG), .SETTLE(SET), .CNTW(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  xprop_sweep_sequencer #(
    .WIDTH(WIDTH), .NGROUPS(NG), .SETTLE(SET), .CNTW(3)
  ) dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  assign sbus.start  = bus.start;
  assign sbus.abort  = 1'b0;
  assign sbus.grp_ok = '0;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  // mode 0: all match, but grp_ok is garbage outside CHECK
  always_comb begin
    bus.grp_ok = 2'b11;
    case (mode)
      0: bus.grp_ok = bus.sample ? 2'b11 : 2'b00;
      1: if (bus.in1_code == 2'b10 && bus.in2_code == 2'b11)
           bus.grp_ok = 2'b01;
      2: bus.grp_ok = 2'b00;
      default: bus.grp_ok = 2'b11;
    endcase
  end

  typedef struct {
    logic [3:0] idx;
    int         cyc;
  } samp_t;

  typedef struct {
    logic        pass;
    logic [15:0] cnt;
    logic [1:0]  mask;
    logic [3:0]  ffidx;
    logic [1:0]  ffmask;
    logic        ffv;
    int          cyc;
  } done_t;

  samp_t sq[$];
  done_t dq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  samp_t s;
  done_t d;
  logic  done_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.sample) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: idx %0d at cycle %0d",
                 {bus.in1_code, bus.in2_code}, cyc);
      end else begin
        s = sq.pop_front();
        chk("sample_idx", {bus.in1_code, bus.in2_code}, s.idx);
        chk("sample_cyc", cyc, s.cyc);
      end
    end
    if (bus.done && !done_prev) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: at cycle %0d", cyc);
      end else begin
        d = dq.pop_front();
        chk("done_cyc", cyc, d.cyc);
        chk("pass", bus.pass, d.pass);
        chk("fail_count", bus.fail_count, d.cnt);
        chk("fail_mask", bus.fail_mask, d.mask);
        chk("ff_idx", bus.first_fail_idx, d.ffidx);
        chk("ff_mask", bus.first_fail_mask, d.ffmask);
        chk("ff_valid", bus.first_fail_valid, d.ffv);
        chk("done_vec_valid", bus.vec_valid, 0);
      end
    end
    done_prev = bus.done;
  end

  task automatic check_zero(string tag);
    chk({tag, "_codes"}, {bus.in1_code, bus.in2_code}, 0);
    chk({tag, "_flags"}, {bus.vec_valid, bus.sample, bus.busy,
                          bus.done, bus.pass, bus.first_fail_valid}, 0);
    chk({tag, "_count"}, bus.fail_count, 0);
    chk({tag, "_masks"}, {bus.fail_mask, bus.first_fail_idx,
                          bus.first_fail_mask}, 0);
  endtask

  // Issue start at the coming edge and queue samples 0..nsamp-1
  task automatic kick(int m, int nsamp);
    int c0;
    @(negedge clk);
    mode = m;
    bus.start = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < nsamp; k++)
      sq.push_back('{idx: 4'(k), cyc: c0 + (k + 1) * (SET + 1) - 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_sweep(int m, logic ep, logic [15:0] ecnt,
                           logic [1:0] emask, logic [3:0] eidx,
                           logic [1:0] effm, logic effv);
    int c0;
    @(negedge clk);
    c0 = cyc + 1;
    dq.push_back('{pass: ep, cnt: ecnt, mask: emask, ffidx: eidx,
                   ffmask: effm, ffv: effv, cyc: c0 + N * (SET + 1)});
    mode = m;
    bus.start = 1'b1;
    for (int k = 0; k < N; k++)
      sq.push_back('{idx: 4'(k), cyc: c0 + (k + 1) * (SET + 1) - 1});
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200 && !bus.done; i++) @(negedge clk);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done %0d required 1", bus.done);
    end
    @(negedge clk);
    chk("left_samples", sq.size(), 0);
    chk("left_done", dq.size(), 0);
  endtask

  task automatic wait_idx(int k);
    for (int i = 0; i < 200; i++) begin
      if ({bus.in1_code, bus.in2_code} == 4'(k) && bus.vec_valid) break;
      @(negedge clk);
    end
    chk("reach_idx", {bus.in1_code, bus.in2_code}, k);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_sweep(0, 1'b1, 16'd0, 2'b00, 4'd0, 2'b00, 1'b0);
    chk("sat_done", sbus.done, 1);
    chk("sat_count", sbus.fail_count, 7);
    chk("sat_pass", sbus.pass, 0);

    run_sweep(1, 1'b0, 16'd1, 2'b10, 4'd11, 2'b10, 1'b1);
    run_sweep(2, 1'b0, 16'd16, 2'b11, 4'd0, 2'b11, 1'b1);

    kick(2, 5);
    wait_idx(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idx(5);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_valid", bus.vec_valid, 0);
    chk("abort_count", bus.fail_count, 5);
    chk("abort_mask", bus.fail_mask, 2'b11);
    @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    chk("abort_left", sq.size(), 0);

    run_sweep(1, 1'b0, 16'd1, 2'b10, 4'd11, 2'b10, 1'b1);

    kick(2, 7);
    wait_idx(7);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    chk("midrst_left", sq.size(), 0);

    run_sweep(0, 1'b1, 16'd0, 2'b00, 4'd0, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
